// File: rtl/store_buffer_if.sv
// Store-port, memory-drain and load-lookup signals of the store buffer.
// slave is the buffer side; master is the pipeline/memory side.
interface store_buffer_if #(
  parameter int ADDR_W = 32
);
  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic [3:0]        st_strb;
  logic              st_stall;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic [3:0]        mem_strb;
  logic              mem_ready;

  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hit;
  logic              ld_full;
  logic [31:0]       ld_data;

  modport master (
    output st_valid, st_addr, st_data, st_strb, mem_ready, ld_addr,
    input  st_stall, mem_valid, mem_addr, mem_data, mem_strb, ld_hit, ld_full, ld_data
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_strb, mem_ready, ld_addr,
    output st_stall, mem_valid, mem_addr, mem_data, mem_strb, ld_hit, ld_full, ld_data
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer: DEPTH-entry FIFO drained over valid/ready, with youngest-match load forwarding.
// Optional STORE_BUF_COALESCE_EN merges same-word stores into the youngest (non-head) entry.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  store_buffer_if.slave         bus,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                  empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WRD_W = ADDR_W - 2;

  typedef logic [PTR_W-1:0] ptr_t;

  logic [WRD_W-1:0] addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       strb_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  ptr_t             head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [WRD_W-1:0] st_word_s, ld_word_s;
  logic             empty_s, stall_s, accept_s, drain_s, merge_s, alloc_s;
  logic             ld_hit_s, ld_match_s;
  ptr_t             ld_sel_s, fwd_idx_s;
  logic             unused_s;

`ifdef STORE_BUF_COALESCE_EN
  ptr_t             youngest_s;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction
`endif

  assign unused_s  = ^{bus.st_addr[1:0], bus.ld_addr[1:0]};
  assign st_word_s = bus.st_addr[ADDR_W-1:2];
  assign ld_word_s = bus.ld_addr[ADDR_W-1:2];

  assign empty_s  = (count_q == CNT_W'(0));
  assign stall_s  = (count_q == CNT_W'(DEPTH));
  assign accept_s = bus.st_valid && !stall_s && (bus.st_strb != 4'h0);
  assign drain_s  = !empty_s && bus.mem_ready;

`ifdef STORE_BUF_COALESCE_EN
  // With two or more entries the youngest is never the head, so merging cannot disturb mem_*.
  assign youngest_s = tail_q - ptr_t'(1);
  assign merge_s    = accept_s && (count_q >= CNT_W'(2)) && valid_q[youngest_s] &&
                      (addr_q[youngest_s] == st_word_s);
`else
  assign merge_s    = 1'b0;
`endif
  assign alloc_s = accept_s && !merge_s;

  // Pointer, occupancy and valid-bit next state
  always_comb begin
    head_d  = drain_s ? head_q + ptr_t'(1) : head_q;
    tail_d  = alloc_s ? tail_q + ptr_t'(1) : tail_q;
    count_d = count_q + CNT_W'(alloc_s) - CNT_W'(drain_s);
    valid_d = valid_q;
    if (drain_s) begin
      valid_d[head_q] = 1'b0;
    end else begin
      valid_d[head_q] = valid_q[head_q];
    end
    if (alloc_s) begin
      valid_d[tail_q] = 1'b1;
    end else begin
      valid_d[tail_q] = valid_d[tail_q];
    end
  end

  // Forwarding scan from head towards tail; the last hit is the youngest
  always_comb begin
    ld_hit_s   = 1'b0;
    ld_sel_s   = head_q;
    fwd_idx_s  = head_q;
    ld_match_s = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx_s  = head_q + ptr_t'(k);
      ld_match_s = valid_q[fwd_idx_s] && (addr_q[fwd_idx_s] == ld_word_s);
      ld_hit_s   = ld_hit_s | ld_match_s;
      ld_sel_s   = ld_match_s ? fwd_idx_s : ld_sel_s;
    end
  end

  // Control state with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= ptr_t'(0);
      tail_q  <= ptr_t'(0);
      count_q <= CNT_W'(0);
      valid_q <= {DEPTH{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry payload storage; contents are qualified by valid_q so no reset is needed
  always_ff @(posedge clk_i) begin
    if (!rst_i && alloc_s) begin
      addr_q[tail_q] <= st_word_s;
      data_q[tail_q] <= bus.st_data;
      strb_q[tail_q] <= bus.st_strb;
    end
`ifdef STORE_BUF_COALESCE_EN
    if (!rst_i && merge_s) begin
      data_q[youngest_s] <= merge_bytes(data_q[youngest_s], bus.st_data, bus.st_strb);
      strb_q[youngest_s] <= strb_q[youngest_s] | bus.st_strb;
    end
`endif
  end

  assign bus.st_stall  = stall_s;
  assign bus.mem_valid = !empty_s;
  assign bus.mem_addr  = empty_s ? {ADDR_W{1'b0}} : {addr_q[head_q], 2'b00};
  assign bus.mem_data  = empty_s ? 32'h0 : data_q[head_q];
  assign bus.mem_strb  = empty_s ? 4'h0 : strb_q[head_q];

  assign bus.ld_hit  = ld_hit_s;
  assign bus.ld_full = ld_hit_s && (strb_q[ld_sel_s] == 4'hF);
  assign bus.ld_data = ld_hit_s ? data_q[ld_sel_s] : 32'h0;

  assign count_o = count_q;
  assign empty_o = empty_s;
endmodule
